npu_dma_master: RTL

Single-channel bus initiator that copies a block of 32-bit words from a source address to a destination address over the NPU system bus. It is the master-side counterpart of the NPU memory interface slave: it drives the transfer type, direction, address and write data that the slave decodes, and it consumes the slave's read data, response and ready. The block sits beside the host CPU on the bus, so the CPU can preload NPU input memory without issuing word-by-word stores.

---
 rtl/npu_dma_master.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/npu_dma_master.sv
// npu_dma_master: single-channel bus initiator that copies len words from src to dst.
// Optional build macro NPU_DMA_FILL_EN adds a fill mode that writes one constant word len times.
`timescale 1ns/1ps

module npu_dma_master #(
    parameter int DWidth   = 32,
    parameter int LenWidth = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                start_i,
    input  logic [DWidth-1:0]   src_addr_i,
    input  logic [DWidth-1:0]   dst_addr_i,
    input  logic [LenWidth-1:0] len_i,
`ifdef NPU_DMA_FILL_EN
    input  logic                fill_i,
    input  logic [DWidth-1:0]   fill_data_i,
`endif
    output logic                busy_o,
    output logic                done_o,
    output logic                err_o,
    output logic [1:0]          trans_o,
    output logic                write_o,
    output logic [DWidth-1:0]   addr_o,
    output logic [DWidth-1:0]   wdata_o,
    input  logic [DWidth-1:0]   rdata_i,
    input  logic                resp_i,
    input  logic                ready_i,
    output logic [2:0]          state_o
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_RD_ADDR = 3'd1;
    localparam logic [2:0] ST_RD_DATA = 3'd2;
    localparam logic [2:0] ST_WR_ADDR = 3'd3;
    localparam logic [2:0] ST_WR_RESP = 3'd4;
    localparam logic [2:0] ST_DONE    = 3'd5;

    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;

    logic [2:0]          state_q, state_d;
    logic [DWidth-1:0]   src_q, dst_q, buf_q;
    logic [LenWidth-1:0] cnt_q;
    logic                err_q;
    logic                fill_mode;
    logic                fill_start;

`ifdef NPU_DMA_FILL_EN
    logic fill_q;
    assign fill_mode  = fill_q;
    assign fill_start = fill_i;
`else
    assign fill_mode  = 1'b0;
    assign fill_start = 1'b0;
`endif

    // Bus handshake: an address or data phase completes on the first cycle with
    // ready_i=1; while ready_i=0 every bus output is held exactly as it was.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    if (len_i == '0)     state_d = ST_DONE;
                    else if (fill_start) state_d = ST_WR_ADDR;
                    else                 state_d = ST_RD_ADDR;
                end
            end
            ST_RD_ADDR: begin
                if (ready_i) state_d = ST_RD_DATA;
            end
            ST_RD_DATA: begin
                if (ready_i) state_d = resp_i ? ST_DONE : ST_WR_ADDR;
            end
            ST_WR_ADDR: begin
                if (ready_i) state_d = ST_WR_RESP;
            end
            ST_WR_RESP: begin
                if (ready_i) begin
                    if (resp_i || cnt_q == LenWidth'(1)) state_d = ST_DONE;
                    else if (fill_mode)                 state_d = ST_WR_ADDR;
                    else                                state_d = ST_RD_ADDR;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            cnt_q   <= '0;
            buf_q   <= '0;
            err_q   <= 1'b0;
`ifdef NPU_DMA_FILL_EN
            fill_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        src_q <= src_addr_i;
                        dst_q <= dst_addr_i;
                        cnt_q <= len_i;
                        err_q <= 1'b0;
`ifdef NPU_DMA_FILL_EN
                        fill_q <= fill_i;
                        if (fill_i) buf_q <= fill_data_i;
`endif
                    end
                end
                ST_RD_DATA: begin
                    if (ready_i) begin
                        if (resp_i) err_q <= 1'b1;
                        else        buf_q <= rdata_i;
                    end
                end
                ST_WR_RESP: begin
                    if (ready_i) begin
                        if (resp_i) begin
                            err_q <= 1'b1;
                        end else begin
                            // Address arithmetic wraps naturally at 2^DWidth.
                            src_q <= src_q + DWidth'(4);
                            dst_q <= dst_q + DWidth'(4);
                            cnt_q <= cnt_q - LenWidth'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Bus outputs decode only from registered state so no ready/resp path reaches them.
    always_comb begin
        trans_o = TRANS_IDLE;
        write_o = 1'b0;
        addr_o  = '0;
        case (state_q)
            ST_RD_ADDR: begin
                trans_o = TRANS_NONSEQ;
                addr_o  = {src_q[DWidth-1:2], 2'b00};
            end
            ST_WR_ADDR: begin
                trans_o = TRANS_NONSEQ;
                write_o = 1'b1;
                addr_o  = {dst_q[DWidth-1:2], 2'b00};
            end
            default: ;
        endcase
    end

    assign wdata_o = buf_q;
    assign busy_o  = (state_q != ST_IDLE);
    assign done_o  = (state_q == ST_DONE);
    assign err_o   = err_q;
    assign state_o = state_q;

endmodule
